div_seq: RTL and testbench

Parametrised multicycle integer divider for the datapath's DIV/DIVU instructions: one quotient bit per clock (restoring algorithm), signed or unsigned mode per operation, start/done handshake, divide-by-zero flag. Results go to the HI (remainder) and LO (quotient) registers. It sits beside the multiplier under control-unit sequencing, and the control unit stalls on `busy`.

---
 rtl/div_seq.sv | 109 ++++++++++
 tb/tb_div_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Multicycle restoring divider for DIV/DIVU: one quotient bit per clock,
// remainder to hi, quotient to lo, divide-by-zero reported through div0.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sign_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one restoring iteration per cycle
  // FIX   | apply signs, write hi/lo, pulse done
  // ZERO  | divisor was zero: set div0, pulse done
  typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} state_t;

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             q_neg;
  logic             r_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] trial;

  // Negating the most negative value yields the correct unsigned magnitude.
  assign a_mag  = (sign_mode && a[WIDTH-1]) ? -a : a;
  assign b_mag  = (sign_mode && b[WIDTH-1]) ? -b : b;
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign trial  = rem_sh - {2'b00, dvs};
  assign busy   = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (b == '0) ? ZERO : RUN;
      RUN:     if (cnt == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      ZERO:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      div0  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (b != '0)) begin
            quo   <= a_mag;
            dvs   <= b_mag;
            q_neg <= sign_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            r_neg <= sign_mode & a[WIDTH-1];
            rem   <= '0;
            cnt   <= CW'(WIDTH);
            div0  <= 1'b0;
          end
        end
        RUN: begin
          // trial MSB set means the subtraction went negative: restore.
          rem <= trial[WIDTH+1] ? rem_sh[WIDTH:0] : trial[WIDTH:0];
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH+1]};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          lo   <= q_neg ? -quo : quo;
          hi   <= r_neg ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          done <= 1'b1;
        end
        ZERO: begin
          div0 <= 1'b1;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed 32-bit cases plus a random 8-bit
// sweep, checked against plain-arithmetic division in the bench.
module tb_div_seq;

  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] hi;
    logic [63:0] lo;
    logic        div0;
    logic [31:0] cyc;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  // 32-bit instance
  logic        rst32 = 1'b1, start32 = 1'b0, sm32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0, hi32, lo32;
  logic        busy32, done32, div0_32;

  // 8-bit instance
  logic        rst8 = 1'b1, start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, hi8, lo8;
  logic        busy8, done8, div0_8;

  div_seq #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(rst32), .start(start32), .sign_mode(sm32),
    .a(a32), .b(b32), .hi(hi32), .lo(lo32),
    .busy(busy32), .done(done32), .div0(div0_32)
  );

  div_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(rst8), .start(start8), .sign_mode(sm8),
    .a(a8), .b(b8), .hi(hi8), .lo(lo8),
    .busy(busy8), .done(done8), .div0(div0_8)
  );

  exp_t q32[$];
  exp_t q8[$];
  logic [63:0] m_hi32 = '0, m_lo32 = '0, m_hi8 = '0, m_lo8 = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Truncating division on w-bit operands, interpreted as two's complement when s=1.
  function automatic void ref_div(input int w, input logic [63:0] av, input logic [63:0] bv,
                                  input bit s, output logic [63:0] q, output logic [63:0] r);
    longint sa, sb, qq, rr, span;
    logic [63:0] mask;
    span = 64'sd1 <<< w;
    mask = (64'd1 << w) - 64'd1;
    sa = $signed(av & mask);
    sb = $signed(bv & mask);
    if (s && av[w-1]) sa = sa - span;
    if (s && bv[w-1]) sb = sb - span;
    qq = sa / sb;
    rr = sa % sb;
    q = qq & mask;
    r = rr & mask;
  endfunction

  task automatic issue32(input logic [31:0] av, input logic [31:0] bv, input bit s);
    exp_t e;
    logic [63:0] q, r;
    a32 = av; b32 = bv; sm32 = s; start32 = 1'b1;
    e.a = {32'd0, av};
    e.b = {32'd0, bv};
    e.cyc = cyc + 1 + ((bv == 0) ? 1 : 33);
    if (bv == 0) begin
      e.hi = m_hi32; e.lo = m_lo32; e.div0 = 1'b1;
    end else begin
      ref_div(32, e.a, e.b, s, q, r);
      e.hi = r; e.lo = q; e.div0 = 1'b0;
      m_hi32 = r; m_lo32 = q;
    end
    q32.push_back(e);
    @(negedge clock);
    start32 = 1'b0;
    a32 = $urandom; b32 = $urandom; sm32 = $urandom_range(0, 1);
  endtask

  task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input bit s);
    exp_t e;
    logic [63:0] q, r;
    a8 = av; b8 = bv; sm8 = s; start8 = 1'b1;
    e.a = {56'd0, av};
    e.b = {56'd0, bv};
    e.cyc = cyc + 1 + ((bv == 0) ? 1 : 9);
    if (bv == 0) begin
      e.hi = m_hi8; e.lo = m_lo8; e.div0 = 1'b1;
    end else begin
      ref_div(8, e.a, e.b, s, q, r);
      e.hi = r; e.lo = q; e.div0 = 1'b0;
      m_hi8 = r; m_lo8 = q;
    end
    q8.push_back(e);
    @(negedge clock);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);
  endtask

  task automatic wait_done32();
    int n = 0;
    while (!done32 && n < 200) begin @(negedge clock); n++; end
    if (!done32) begin checks++; $display("FAIL wait_done32: no done within %0d cycles", n); end
  endtask

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 100) begin @(negedge clock); n++; end
    if (!done8) begin checks++; $display("FAIL wait_done8: no done within %0d cycles", n); end
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!rst32 && done32) begin
      if (q32.size() == 0) begin
        checks++;
        $display("FAIL done32_unexpected: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = q32.pop_front();
        chk("latency32", 64'(cyc), 64'(e.cyc));
        chk("hi32", {32'd0, hi32}, e.hi);
        chk("lo32", {32'd0, lo32}, e.lo);
        chk("div0_32", {63'd0, div0_32}, {63'd0, e.div0});
        chk("busy_at_done32", {63'd0, busy32}, 64'd0);
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (!rst8 && done8) begin
      if (q8.size() == 0) begin
        checks++;
        $display("FAIL done8_unexpected: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        e = q8.pop_front();
        chk("latency8", 64'(cyc), 64'(e.cyc));
        chk("hi8", {56'd0, hi8}, e.hi);
        chk("lo8", {56'd0, lo8}, e.lo);
        chk("div0_8", {63'd0, div0_8}, {63'd0, e.div0});
        chk("busy_at_done8", {63'd0, busy8}, 64'd0);
        if (!e.div0)
          chk("identity8", ((64'(lo8) * e.b) + 64'(hi8)) & 64'hFF, e.a);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed { logic [7:0] a; logic [7:0] b; logic s; } c8_t;
  c8_t corners8[6];

  initial begin
    corners8[0] = {8'h80, 8'hFF, 1'b1};
    corners8[1] = {8'h80, 8'hFF, 1'b0};
    corners8[2] = {8'hFF, 8'h01, 1'b0};
    corners8[3] = {8'h7F, 8'h80, 1'b1};
    corners8[4] = {8'h05, 8'h00, 1'b1};
    corners8[5] = {8'hF9, 8'h02, 1'b1};

    repeat (3) @(negedge clock);
    chk("rst_hi32", {32'd0, hi32}, 64'd0);
    chk("rst_lo32", {32'd0, lo32}, 64'd0);
    chk("rst_busy32", {63'd0, busy32}, 64'd0);
    chk("rst_done32", {63'd0, done32}, 64'd0);
    chk("rst_div0_32", {63'd0, div0_32}, 64'd0);
    chk("rst_busy8", {63'd0, busy8}, 64'd0);
    rst32 = 1'b0; rst8 = 1'b0;
    @(negedge clock);

    issue32(32'd100, 32'd7, 1'b0);
    chk("busy_after_start32", {63'd0, busy32}, 64'd1);
    wait_done32();
    // back-to-back on the done cycle, divide by zero keeps hi/lo
    issue32(32'd5, 32'd0, 1'b0);
    wait_done32();
    repeat (3) @(negedge clock);
    chk("div0_hold", {63'd0, div0_32}, 64'd1);
    issue32(32'hFFFF_FFF9, 32'd2, 1'b1);
    chk("div0_cleared", {63'd0, div0_32}, 64'd0);
    wait_done32();
    issue32(32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done32();
    issue32(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done32();
    issue32(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done32();
    issue32(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done32();

    // start pulses while busy must be ignored
    issue32(32'd1000, 32'd3, 1'b0);
    repeat (4) @(negedge clock);
    a32 = 32'd1; b32 = 32'd0; start32 = 1'b1;
    @(negedge clock);
    a32 = 32'd77; b32 = 32'd5; start32 = 1'b1;
    @(negedge clock);
    start32 = 1'b0;
    wait_done32();
    repeat (40) @(negedge clock);

    // reset in the middle of RUN
    issue32(32'd12345, 32'd17, 1'b0);
    repeat (9) @(negedge clock);
    rst32 = 1'b1;
    @(negedge clock);
    chk("midrst_hi32", {32'd0, hi32}, 64'd0);
    chk("midrst_lo32", {32'd0, lo32}, 64'd0);
    chk("midrst_busy32", {63'd0, busy32}, 64'd0);
    chk("midrst_done32", {63'd0, done32}, 64'd0);
    chk("midrst_div0_32", {63'd0, div0_32}, 64'd0);
    q32.delete();
    m_hi32 = '0; m_lo32 = '0;
    rst32 = 1'b0;
    repeat (40) @(negedge clock);
    issue32(32'hFFFF_FFB1, 32'd9, 1'b1);
    wait_done32();
    @(negedge clock);

    for (int i = 0; i < 6; i++) begin
      issue8(corners8[i].a, corners8[i].b, corners8[i].s);
      wait_done8();
    end
    for (int i = 0; i < 200; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
      issue8(ra, rb, 1'($urandom_range(0, 1)));
      wait_done8();
    end

    repeat (12) @(negedge clock);
    chk("queue32_empty", 64'(q32.size()), 64'd0);
    chk("queue8_empty", 64'(q8.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
